// File: rtl/mdu_seq_if.sv
// Handshake and data bundle between the EX stage and the sequential multiply/divide unit.
// The EX stage uses the master view; the unit uses the slave view.
`timescale 1ns/1ps
interface mdu_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wd;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;

  modport master (
    output start, op, a, b, flush, hi_we, lo_we, wd,
    input  busy, done, hi, lo, div_zero
  );

  modport slave (
    input  start, op, a, b, flush, hi_we, lo_we, wd,
    output busy, done, hi, lo, div_zero
  );
endinterface

// File: rtl/mdu_seq.sv
// Sequential multiply/divide unit with HI/LO registers: shift-add multiply, restoring divide,
// one iteration per cycle, sign fix-up applied in a final cycle.
`timescale 1ns/1ps
module mdu_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CW    = $clog2(WIDTH) + 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  mdu_seq_if.slave   bus
);

  localparam int unsigned W2 = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_trial;
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  always_comb begin
    a_abs = (bus.op[0] && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    b_abs = (bus.op[0] && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  end

  // acc holds {partial product, remaining multiplier} or {remainder, dividend/quotient}
  always_comb begin
    mul_sum   = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    div_trial = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, b_q};
  end

  always_comb begin
    prod_fix = (op_q[0] && (sa_q ^ sb_q)) ? -acc_q : acc_q;
    quo_fix  = (op_q[0] && (sa_q ^ sb_q)) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = (op_q[0] && sa_q) ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dz_d    = dz_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.hi_we) hi_d = bus.wd;
        if (bus.lo_we) lo_d = bus.wd;
        if (bus.start && !bus.flush) begin
          op_d    = bus.op;
          sa_d    = bus.op[0] & bus.a[WIDTH-1];
          sb_d    = bus.op[0] & bus.b[WIDTH-1];
          a_d     = bus.a;
          b_d     = b_abs;
          acc_d   = {{WIDTH{1'b0}}, a_abs};
          dz_d    = 1'b0;
          cnt_d   = CW'(WIDTH);
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          if (op_q[1]) begin
            // Restoring step: keep the difference only when the trial did not borrow
            if (!div_trial[WIDTH]) acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else                   acc_d = {acc_q[W2-2:0], 1'b0};
          end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = S_FIX;
        end
      end

      S_FIX: begin
        state_d = S_IDLE;
        if (!bus.flush) begin
          done_d = 1'b1;
          if (!op_q[1]) begin
            hi_d = prod_fix[W2-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end else if (b_q == '0) begin
            hi_d = a_q;
            lo_d = '1;
            dz_d = 1'b1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = done_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.div_zero = dz_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Randomised and directed bench for mdu_seq at WIDTH=32 against a plain-arithmetic HI/LO model.
`timescale 1ns/1ps
module tb_mdu_seq;

  localparam int unsigned WIDTH = 32;
  localparam int          LAT   = WIDTH + 1;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  mdu_seq_if #(.WIDTH(WIDTH)) bus ();

  mdu_seq #(.WIDTH(WIDTH)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns {div_zero, hi, lo} from the architectural arithmetic rules.
  function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint      sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: begin
        p = {32'h0, a} * {32'h0, b};
        return {1'b0, p};
      end
      2'b01: begin
        p = 64'(sa * sb);
        return {1'b0, p};
      end
      default: begin
        if (b == 32'h0) return {1'b1, a, 32'hFFFF_FFFF};
        if (op == 2'b10) return {1'b0, a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'h0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  // Issue one operation; optionally poke a second start and an MTLO while busy.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit poke);
    logic [64:0] exp;
    logic [31:0] lo_before;
    int          cyc;
    int          busy_cnt;
    exp = model(op, a, b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lo_before = bus.lo;
    check("done_low_after_accept", 64'(bus.done), 64'h0);
    busy_cnt = bus.busy ? 1 : 0;
    cyc = 0;
    while (!bus.done && cyc < 3 * LAT) begin
      bus.start = poke && (cyc == 4);
      if (bus.start) begin
        bus.a = $urandom;
        bus.b = $urandom;
      end
      bus.lo_we = poke && (cyc == 6);
      bus.wd    = $urandom;
      @(posedge clk); #1;
      cyc++;
      if (bus.busy) busy_cnt++;
      if (poke && cyc == 7) check("lo_we_while_busy", 64'(bus.lo), 64'(lo_before));
    end
    bus.start = 1'b0;
    bus.lo_we = 1'b0;
    check("latency", 64'(cyc), 64'(LAT));
    check("busy_cycles", 64'(busy_cnt), 64'(LAT));
    check("busy_low_at_done", 64'(bus.busy), 64'h0);
    check("hi", 64'(bus.hi), 64'(exp[63:32]));
    check("lo", 64'(bus.lo), 64'(exp[31:0]));
    check("div_zero", 64'(bus.div_zero), 64'(exp[64]));
  endtask

  initial begin
    logic [31:0] hi_prev, lo_prev;
    int          done_seen;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    bus.flush = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wd    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(bus.busy), 64'h0);
    check("rst_done", 64'(bus.done), 64'h0);
    check("rst_hi", 64'(bus.hi), 64'h0);
    check("rst_lo", 64'(bus.lo), 64'h0);
    check("rst_dz", 64'(bus.div_zero), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    do_op(2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 1'b0);
    do_op(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    do_op(2'b10, 32'h0000_0007, 32'h0000_0000, 1'b0);
    do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

    for (int i = 0; i < 40; i++)
      do_op(2'($urandom_range(0, 3)), pick(), pick(), (i % 5) == 0);

    // Flush mid-divide together with a competing start
    do_op(2'b00, 32'h0001_2345, 32'h0000_6789, 1'b0);
    hi_prev = bus.hi;
    lo_prev = bus.lo;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b10;
    bus.a     = 32'hDEAD_BEEF;
    bus.b     = 32'h0000_0013;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.start = 1'b0;
    check("flush_busy", 64'(bus.busy), 64'h0);
    done_seen = 0;
    for (int i = 0; i < 2 * LAT; i++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) done_seen++;
    end
    check("flush_no_done", 64'(done_seen), 64'h0);
    check("flush_hi_hold", 64'(bus.hi), 64'(hi_prev));
    check("flush_lo_hold", 64'(bus.lo), 64'(lo_prev));

    // MTHI while idle
    @(negedge clk);
    bus.hi_we = 1'b1;
    bus.wd    = 32'h1234_5678;
    @(posedge clk); #1;
    bus.hi_we = 1'b0;
    check("mthi", 64'(bus.hi), 64'h1234_5678);

    // Reset while idle with div_zero set, then reset mid-run
    do_op(2'b10, 32'h0000_0007, 32'h0000_0000, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_idle_hi", 64'(bus.hi), 64'h0);
    check("rst_idle_lo", 64'(bus.lo), 64'h0);
    check("rst_idle_dz", 64'(bus.div_zero), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.a     = 32'd123;
    bus.b     = 32'd456;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_run_busy", 64'(bus.busy), 64'h0);
    check("rst_run_done", 64'(bus.done), 64'h0);
    check("rst_run_hi", 64'(bus.hi), 64'h0);
    check("rst_run_lo", 64'(bus.lo), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(2'b00, 32'd6, 32'd7, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

endmodule
